mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ACC_CYCLES, default 4: clk cycles one memory access holds the port; legal range 2..15.
REQ-002 SHALL have ports clk (in, 1): rising-edge clock, the only clock; rst_n (in, 1): reset, synchronous and active-low.
REQ-003 SHALL have mcu_rrq, mcu_wrq (in, 1 each): single-cycle MCU read and write request pulses.
REQ-004 SHALL have mcu_addr (in, 24) and mcu_wdata (in, 8): MCU address and write data, sampled on the request pulse.
REQ-005 SHALL have mcu_rdata (out, 8): registered MCU read data.
REQ-006 SHALL have mcu_rq_rdy (out, 1): MCU ready level; low while an MCU request is pending or in service.
REQ-007 SHALL have dma_we (in, 1), dma_addr (in, 24), dma_wdata (in, 8): SD DMA write pulse, address and data.
REQ-008 SHALL have dma_rdy (out, 1): DMA ready level; low while a DMA write is pending or in service.
REQ-009 SHALL have snes_hold (in, 1): while high, no new access starts.
REQ-010 SHALL have mem_addr (out, 24), mem_wdata (out, 8), mem_rdata (in, 8), mem_oe_n (out, 1), mem_we_n (out, 1): shared memory port.
REQ-011 SHALL have overrun (out, 2): sticky error flags; bit1 = DMA, bit0 = MCU.

Function
REQ-012 SHALL latch each request into a one-deep pending slot per source (MCU, DMA); MCU slot stores addr, data and a read/write flag.
REQ-013 SHALL set overrun[n] and drop the new request when it arrives while slot n is occupied; the pending request is unaffected.
REQ-014 SHALL treat mcu_rrq and mcu_wrq asserted together as a write, and SHALL set no overrun for this case.
REQ-015 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE.
REQ-016 In IDLE, with snes_hold low and at least one slot full, the FSM SHALL grant one slot and enter ACCESS on the next edge.
REQ-017 Priority SHALL be DMA over MCU, except when the MCU slot is pending and two consecutive grants went to DMA; then MCU wins.
REQ-018 The consecutive-DMA counter (2 bits, saturating at 2) SHALL clear on every MCU grant.
REQ-019 In ACCESS, mem_addr and mem_wdata SHALL hold the granted values for exactly ACC_CYCLES cycles.
REQ-020 In ACCESS, mem_oe_n SHALL be low for reads; mem_we_n SHALL be low for writes during all cycles except the last, giving write recovery.
REQ-021 On the last ACCESS cycle of a read, mem_rdata SHALL be captured into mcu_rdata.
REQ-022 In DONE (one cycle), the granted slot SHALL be freed and its ready output SHALL return high in the same cycle.
REQ-023 Request-to-ready latency from IDLE with no contention and snes_hold low SHALL be ACC_CYCLES+2 cycles.
REQ-024 A request arriving in the DONE cycle of its own slot SHALL be accepted, not flagged as overrun.
REQ-025 snes_hold asserting mid-ACCESS SHALL NOT abort or stretch the current access.
REQ-026 Outside ACCESS, mem_oe_n and mem_we_n SHALL be high; mem_addr and mem_wdata SHALL hold their last values.
REQ-027 Overrun flags SHALL clear only by reset.

Reset
REQ-028 With rst_n low at an edge: FSM to IDLE, slots empty, counter 0, mcu_rq_rdy=1, dma_rdy=1, mem_oe_n=1, mem_we_n=1, mem_addr=0, mem_wdata=0, mcu_rdata=0, overrun=0.
REQ-029 Reset mid-ACCESS SHALL deassert the strobes on that edge and discard all pending requests.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, the source IDs (SRC_MCU, SRC_DMA) and the ACC_CYCLES bounds.
REQ-031 The design SHALL be a single module, with no sub-module.

Verification
REQ-032 Bench SHALL cover the idle MCU read: mcu_rrq at 0x123456, mem_rdata=0xA5, ACC_CYCLES=4 -> mem_oe_n low for 4 cycles, mcu_rdata=0xA5, mcu_rq_rdy high 6 cycles after the request.
REQ-033 Bench SHALL cover a continuous DMA stream: dma_we every cycle dma_rdy is high, with MCU write 0x77 pending -> grant order DMA, DMA, MCU, DMA; the MCU write completes.
REQ-034 Bench SHALL cover a double request: second mcu_wrq while the first is pending -> overrun=2'b01, the first write completes, the second never reaches mem_we_n.
REQ-035 Bench SHALL cover snes_hold: held high for 10 cycles with both slots full -> no strobe during hold; DMA is granted the cycle after release.
REQ-036 Bench SHALL cover reset mid-ACCESS: rst_n low during DMA write cycle 2 -> strobes high on that edge, dma_rdy=1, and no access after rst_n returns high.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and limits for the memory port arbiter.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   typedef enum logic {
      SRC_MCU = 1'b0,
      SRC_DMA = 1'b1
   } src_t;

   localparam int unsigned ACC_CYCLES_MIN = 2;
   localparam int unsigned ACC_CYCLES_MAX = 15;
   localparam int unsigned DMA_STREAK_MAX = 2;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between an MCU (read/write) and an SD DMA
// write stream, each through a one-deep pending slot.
//
// state  | meaning
// IDLE   | port free; grant a pending slot unless snes_hold is high
// ACCESS | drive granted address/data and strobes for ACC_CYCLES cycles
// DONE   | free the granted slot; its ready output is already high
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ACC_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mcu_rrq,
   input  logic        mcu_wrq,
   input  logic [23:0] mcu_addr,
   input  logic [7:0]  mcu_wdata,
   output logic [7:0]  mcu_rdata,
   output logic        mcu_rq_rdy,
   input  logic        dma_we,
   input  logic [23:0] dma_addr,
   input  logic [7:0]  dma_wdata,
   output logic        dma_rdy,
   input  logic        snes_hold,
   output logic [23:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic        mem_oe_n,
   output logic        mem_we_n,
   output logic [1:0]  overrun
);

   // Out-of-range parameter values are clamped to the legal span.
   localparam int unsigned ACC_EFF =
      (ACC_CYCLES < ACC_CYCLES_MIN) ? ACC_CYCLES_MIN :
      (ACC_CYCLES > ACC_CYCLES_MAX) ? ACC_CYCLES_MAX : ACC_CYCLES;
   localparam logic [3:0] ACC_LAST   = 4'(ACC_EFF - 1);
   localparam logic [1:0] STREAK_MAX = 2'(DMA_STREAK_MAX);

   state_t      state, state_nxt;
   src_t        gnt_src, grant_src;
   logic        grant_go;
   logic        gnt_wr;
   logic [3:0]  acc_cnt;
   logic        acc_last;
   logic [1:0]  dma_streak;

   logic        mcu_full, mcu_wr;
   logic [23:0] mcu_slot_addr;
   logic [7:0]  mcu_slot_data;
   logic        dma_full;
   logic [23:0] dma_slot_addr;
   logic [7:0]  dma_slot_data;

   logic        mcu_req, mcu_free, dma_free;

   assign mcu_req  = mcu_rrq | mcu_wrq;
   assign acc_last = (acc_cnt == 4'd0);
   assign mcu_free = (state == ST_DONE) && (gnt_src == SRC_MCU);
   assign dma_free = (state == ST_DONE) && (gnt_src == SRC_DMA);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      grant_go  = 1'b0;
      grant_src = SRC_MCU;
      unique case (state)
         ST_IDLE: begin
            if (!snes_hold && (mcu_full || dma_full)) begin
               grant_go  = 1'b1;
               grant_src = (dma_full && !(mcu_full && dma_streak == STREAK_MAX))
                           ? SRC_DMA : SRC_MCU;
               state_nxt = ST_ACCESS;
            end
         end
         ST_ACCESS: if (acc_last) state_nxt = ST_DONE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcu_full      <= 1'b0;
         mcu_wr        <= 1'b0;
         mcu_slot_addr <= '0;
         mcu_slot_data <= '0;
         dma_full      <= 1'b0;
         dma_slot_addr <= '0;
         dma_slot_data <= '0;
         overrun       <= 2'b00;
         gnt_src       <= SRC_MCU;
         gnt_wr        <= 1'b0;
         acc_cnt       <= '0;
         dma_streak    <= '0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         mcu_rdata     <= '0;
      end else begin
         // A slot being freed in DONE may take a new request on the same edge.
         if (mcu_req && (!mcu_full || mcu_free)) begin
            mcu_full      <= 1'b1;
            mcu_wr        <= mcu_wrq;
            mcu_slot_addr <= mcu_addr;
            mcu_slot_data <= mcu_wdata;
         end else if (mcu_free) begin
            mcu_full <= 1'b0;
         end
         if (mcu_req && mcu_full && !mcu_free) overrun[0] <= 1'b1;

         if (dma_we && (!dma_full || dma_free)) begin
            dma_full      <= 1'b1;
            dma_slot_addr <= dma_addr;
            dma_slot_data <= dma_wdata;
         end else if (dma_free) begin
            dma_full <= 1'b0;
         end
         if (dma_we && dma_full && !dma_free) overrun[1] <= 1'b1;

         if (grant_go) begin
            gnt_src <= grant_src;
            acc_cnt <= ACC_LAST;
            if (grant_src == SRC_DMA) begin
               gnt_wr     <= 1'b1;
               mem_addr   <= dma_slot_addr;
               mem_wdata  <= dma_slot_data;
               dma_streak <= (dma_streak == STREAK_MAX) ? dma_streak : dma_streak + 2'd1;
            end else begin
               gnt_wr     <= mcu_wr;
               mem_addr   <= mcu_slot_addr;
               mem_wdata  <= mcu_slot_data;
               dma_streak <= 2'd0;
            end
         end else if (state == ST_ACCESS && !acc_last) begin
            acc_cnt <= acc_cnt - 4'd1;
         end

         if (state == ST_ACCESS && acc_last && !gnt_wr) mcu_rdata <= mem_rdata;
      end
   end

   // Write strobe releases one cycle early for write recovery.
   assign mem_oe_n   = !((state == ST_ACCESS) && !gnt_wr);
   assign mem_we_n   = !((state == ST_ACCESS) && gnt_wr && !acc_last);
   assign mcu_rq_rdy = !mcu_full || mcu_free;
   assign dma_rdy    = !dma_full || dma_free;

endmodule
